dram_lsu: RTL

- Load/store initiator between the execute stage and the word-addressed `dram` data memory.
- Accepts byte-addressed RV32 LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake.
- Drives `dram`'s `load`/`store`/`addr_a`/`data_in`, which has 1-cycle read latency and no byte enables. Sub-word stores therefore use read-modify-write.
- Returns sign/zero-extended load data or store completion over a valid/ready response channel. Flags misaligned accesses without touching memory.

---
 rtl/dram_lsu_pkg.sv | 38 +++
 rtl/dram_lsu_lane_align.sv | 44 ++++
 rtl/dram_lsu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dram_lsu_pkg.sv
// Shared configuration and types for the load/store unit in front of the
// word-addressed data memory.
//   CFG_XLEN     : data path width
//   CFG_ADDR_LEN : memory word-address width
//   mem_size_e   : access size encoding as carried on req_size (2'b11 is illegal)
//   lsu_state_e  : access sequencer states
package dram_lsu_pkg;

    localparam int CFG_XLEN     = 32;
    localparam int CFG_ADDR_LEN = 10;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LD_ISSUE   = 3'd1,
        LD_CAPTURE = 3'd2,
        ST_WORD    = 3'd3,
        RMW_READ   = 3'd4,
        RMW_WRITE  = 3'd5,
        RESP       = 3'd6
    } lsu_state_e;

    // Illegal size, or a half/word whose byte lane does not line up with its size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_B:   is_misaligned = 1'b0;
            MEM_H:   is_misaligned = lane[0];
            MEM_W:   is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dram_lsu_lane_align.sv
// Byte-lane steering between a memory word and the core's low-aligned data.
//   ld_word/lane/size/is_unsigned -> ld_data   : lane extract + sign/zero extend
//   st_old/st_new/lane/size       -> st_merged : st_old with the target lane
//                                                replaced by the low bits of st_new
// Purely combinational. Callers guarantee the access is aligned.
module lsu_lane_align
    import dram_lsu_pkg::*;
#(
    parameter int XLEN = CFG_XLEN
) (
    input  logic [XLEN-1:0] ld_word,
    input  logic [1:0]      lane,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] ld_data,
    input  logic [XLEN-1:0] st_old,
    input  logic [XLEN-1:0] st_new,
    output logic [XLEN-1:0] st_merged
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = ld_word >> {lane, 3'b000};
        case (size)
            MEM_B:   ld_data = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                           : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEM_H:   ld_data = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                           : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            // Word accesses are always lane 0, so the shift is a pass-through.
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        st_merged = st_old;
        case (size)
            MEM_B:   st_merged[{lane, 3'b000} +: 8]     = st_new[7:0];
            MEM_H:   st_merged[{lane[1], 4'b0000} +: 16] = st_new[15:0];
            default: st_merged = st_new;
        endcase
    end

endmodule

// File: rtl/dram_lsu.sv
// Load/store initiator between the execute stage and the word-addressed data
// memory (1-cycle read latency, no byte enables).
//   req_*  : byte-addressed load/store request, valid/ready
//   resp_* : extended load data / store completion / misaligned flag, valid/ready
//   mem_*  : memory word address, read/write strobes, write data, read data
// Sub-word stores are done as read-modify-write. Misaligned or illegal-size
// requests respond immediately without touching memory.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | ready for a request; only state with req_ready=1
//   LD_ISSUE   | mem_load for a load
//   LD_CAPTURE | mem_rdata valid; extract/extend lane into resp_rdata
//   ST_WORD    | mem_store of a full word
//   RMW_READ   | mem_load of the word a sub-word store will modify
//   RMW_WRITE  | mem_store of old word with the target lane replaced
//   RESP       | resp_valid held until resp_ready
module dram_lsu
    import dram_lsu_pkg::*;
#(
    parameter int XLEN     = CFG_XLEN,
    parameter int ADDR_LEN = CFG_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_misaligned,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_load,
    output logic                mem_store,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata
);

    lsu_state_e          state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q;
    logic [1:0]          lane_q;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rdata_q;
    logic                mis_q;

    logic                req_mis;
    logic                accept;
    logic [XLEN-1:0]     ld_data;
    logic [XLEN-1:0]     st_merged;

    // Address bits above the memory's word index wrap and are intentionally dropped.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_LEN+2];

    assign req_mis = is_misaligned(req_size, req_addr[1:0]);
    assign accept  = (state_q == IDLE) && req_valid;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .ld_word     (mem_rdata),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .ld_data     (ld_data),
        .st_old      (mem_rdata),
        .st_new      (wdata_q),
        .st_merged   (st_merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= req_addr[ADDR_LEN+1:2];
                lane_q     <= req_addr[1:0];
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
                mis_q      <= req_mis;
            end
            if (state_q == LD_CAPTURE) begin
                rdata_q <= ld_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_load   = 1'b0;
        mem_store  = 1'b0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_mis)                state_d = RESP;
                    else if (!req_we)           state_d = LD_ISSUE;
                    else if (req_size == MEM_W) state_d = ST_WORD;
                    else                        state_d = RMW_READ;
                end
            end
            LD_ISSUE: begin
                mem_load = 1'b1;
                state_d  = LD_CAPTURE;
            end
            LD_CAPTURE: state_d = RESP;
            ST_WORD: begin
                mem_store = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RMW_READ: begin
                mem_load = 1'b1;
                state_d  = RMW_WRITE;
            end
            RMW_WRITE: begin
                mem_store = 1'b1;
                mem_wdata = st_merged;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign mem_addr        = addr_q;

endmodule
